// File: rtl/fifo_seq_player.sv
// Record/playback sequencer: events are captured into a ring buffer and replayed one per PERIOD_CNT clocks.
// Optional FIFO_SEQ_ONEHOT_EN: stores the one-hot of the lowest set bit and ignores all-zero events.
module fifo_seq_player #(
  parameter int WIDTH      = 4,
  parameter int LOGDEPTH   = 3,
  parameter int PERIOD_CNT = 125_000_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          mode,
  input  logic                clear,
  input  logic                in_valid,
  input  logic [WIDTH-1:0]    in_data,
  output logic [WIDTH-1:0]    out_data,
  output logic                out_valid,
  output logic [LOGDEPTH:0]   count,
  output logic                full,
  output logic                empty,
  output logic                overflow
);

  typedef enum logic [1:0] {
    MODE_HOLD   = 2'b00,
    MODE_RECORD = 2'b01,
    MODE_PLAY   = 2'b10,
    MODE_LOOP   = 2'b11
  } mode_e;

  localparam int DEPTH = 1 << LOGDEPTH;
  localparam int TW    = (PERIOD_CNT > 2) ? $clog2(PERIOD_CNT) : 1;
  localparam logic [TW-1:0]     TIMER_MAX = TW'(PERIOD_CNT - 1);
  localparam logic [LOGDEPTH:0] COUNT_MAX = (LOGDEPTH + 1)'(DEPTH);

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [LOGDEPTH-1:0] wr_ptr;
  logic [LOGDEPTH-1:0] rd_ptr;
  logic [LOGDEPTH-1:0] li;
  logic [TW-1:0]       timer;
  mode_e               mode_q;
  mode_e               mode_cur;

  logic                mode_change;
  logic                tick;
  logic                accept;
  logic [WIDTH-1:0]    wr_data;
  logic                rec;
  logic                do_write;
  logic                play_rd;
  logic                loop_rd;
  logic [LOGDEPTH-1:0] loop_addr;
  logic                loop_last;

  assign full  = (count == COUNT_MAX);
  assign empty = (count == '0);

  always_comb begin
    mode_cur    = mode_e'(mode);
    mode_change = (mode_cur != mode_q);
    tick        = (timer == TIMER_MAX) && !mode_change && mode_cur[1];
`ifdef FIFO_SEQ_ONEHOT_EN
    // x & -x isolates the lowest set bit
    wr_data = in_data & (~in_data + 1'b1);
    accept  = in_valid && (in_data != '0);
`else
    wr_data = in_data;
    accept  = in_valid;
`endif
    rec       = (mode_cur == MODE_RECORD) && accept;
    do_write  = rec && !full && !clear;
    play_rd   = tick && (mode_cur == MODE_PLAY) && !empty;
    loop_rd   = tick && (mode_cur == MODE_LOOP) && !empty;
    loop_addr = rd_ptr + li;
    loop_last = ({1'b0, li} == (count - 1'b1));
  end

  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      li        <= '0;
      count     <= '0;
      timer     <= '0;
      mode_q    <= MODE_HOLD;
      out_data  <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      mode_q    <= mode_cur;
      out_valid <= 1'b0;
      if (clear) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        li       <= '0;
        count    <= '0;
        timer    <= '0;
        overflow <= 1'b0;
        out_data <= '0;
      end else begin
        if (mode_change || !mode_cur[1] || (timer == TIMER_MAX)) timer <= '0;
        else timer <= timer + 1'b1;

        if (mode_change) li <= '0;

        if (rec) begin
          if (!full) begin
            wr_ptr <= wr_ptr + 1'b1;
            count  <= count + 1'b1;
          end else begin
            overflow <= 1'b1;
          end
        end

        if (play_rd) begin
          out_data  <= mem[rd_ptr];
          rd_ptr    <= rd_ptr + 1'b1;
          count     <= count - 1'b1;
          out_valid <= 1'b1;
        end

        // loop replay walks li over the stored window without consuming it
        if (loop_rd) begin
          out_data  <= mem[loop_addr];
          li        <= loop_last ? '0 : li + 1'b1;
          out_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_seq_player.sv
// Directed bench for fifo_seq_player (WIDTH=4, LOGDEPTH=2, PERIOD_CNT=4).
// Inputs are driven and outputs sampled on the falling edge.
module tb_fifo_seq_player;
  localparam int W  = 4;
  localparam int LD = 2;
  localparam int P  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic          clear = 1'b0;
  logic          in_valid = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic [LD:0]   count;
  logic          full;
  logic          empty;
  logic          overflow;

  int vectors = 0;
  int miscompares = 0;

  fifo_seq_player #(.WIDTH(W), .LOGDEPTH(LD), .PERIOD_CNT(P)) dut (
    .clk(clk), .rst(rst), .mode(mode), .clear(clear),
    .in_valid(in_valid), .in_data(in_data),
    .out_data(out_data), .out_valid(out_valid), .count(count),
    .full(full), .empty(empty), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    vectors++; if (out_data !== 4'd0) begin miscompares++; $display("FAIL reset_out_data: got %0d want 0", out_data); end
    vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL reset_count: got %0d want 0", count); end
    vectors++; if (empty !== 1'b1 || full !== 1'b0) begin miscompares++; $display("FAIL reset_flags: empty=%b full=%b want 1/0", empty, full); end
    vectors++; if (overflow !== 1'b0 || out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_ovf_valid: ovf=%b valid=%b want 0/0", overflow, out_valid); end
    cyc(); cyc();
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_record_overflow();
    mode = 2'b01;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = (i < 4) ? 4'(1 << i) : 4'd3;
      cyc();
    end
    in_valid = 1'b0;
    vectors++; if (count !== 3'd4) begin miscompares++; $display("FAIL rec_count: got %0d want 4", count); end
    vectors++; if (full !== 1'b1 || empty !== 1'b0) begin miscompares++; $display("FAIL rec_full: full=%b empty=%b want 1/0", full, empty); end
    vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL rec_overflow: got %b want 1", overflow); end
  endtask

  task automatic test_play();
    mode = 2'b10;
    cyc();
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 3; j++) begin
        cyc();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL play_idle%0d_%0d: valid=%b want 0", k, j, out_valid); end
      end
      cyc();
      vectors++; if (out_valid !== 1'b1 || out_data !== 4'(1 << k)) begin miscompares++; $display("FAIL play_tick%0d: valid=%b data=%0d want 1/%0d", k, out_valid, out_data, 1 << k); end
    end
    vectors++; if (empty !== 1'b1 || count !== 3'd0) begin miscompares++; $display("FAIL play_drained: empty=%b count=%0d want 1/0", empty, count); end
    for (int j = 0; j < 10; j++) begin
      cyc();
      vectors++; if (out_valid !== 1'b0 || out_data !== 4'd8) begin miscompares++; $display("FAIL play_after%0d: valid=%b data=%0d want 0/8", j, out_valid, out_data); end
    end
    vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL play_ovf_sticky: got %b want 1", overflow); end
  endtask

  task automatic test_loop();
    mode = 2'b01;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 4'(5 + i);
      cyc();
    end
    in_valid = 1'b0;
    vectors++; if (count !== 3'd3) begin miscompares++; $display("FAIL loop_rec_count: got %0d want 3", count); end
    mode = 2'b11;
    cyc();
    for (int k = 0; k < 5; k++) begin
      for (int j = 0; j < 3; j++) begin
        cyc();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL loop_idle%0d_%0d: valid=%b want 0", k, j, out_valid); end
      end
      cyc();
      vectors++; if (out_valid !== 1'b1 || out_data !== 4'(5 + (k % 3))) begin miscompares++; $display("FAIL loop_tick%0d: valid=%b data=%0d want 1/%0d", k, out_valid, out_data, 5 + (k % 3)); end
      vectors++; if (count !== 3'd3) begin miscompares++; $display("FAIL loop_count%0d: got %0d want 3", k, count); end
    end
  endtask

  task automatic test_async_reset();
    mode = 2'b10;
    cyc();
    for (int j = 0; j < 3; j++) cyc();
    cyc();
    vectors++; if (out_valid !== 1'b1 || out_data !== 4'd5 || count !== 3'd2) begin miscompares++; $display("FAIL arst_pre: valid=%b data=%0d count=%0d want 1/5/2", out_valid, out_data, count); end
    #2 rst = 1'b1;
    #1;
    vectors++; if (out_data !== 4'd0 || count !== 3'd0 || empty !== 1'b1) begin miscompares++; $display("FAIL arst_immediate: data=%0d count=%0d empty=%b want 0/0/1", out_data, count, empty); end
    #1 rst = 1'b0;
    cyc();
    mode = 2'b01;
    in_valid = 1'b1;
    in_data = 4'd10;
    cyc();
    in_valid = 1'b0;
    mode = 2'b10;
    cyc();
    for (int j = 0; j < 3; j++) begin
      cyc();
      vectors++; if (out_valid !== 1'b0 || out_data !== 4'd0) begin miscompares++; $display("FAIL arst_idle%0d: valid=%b data=%0d want 0/0", j, out_valid, out_data); end
    end
    cyc();
    vectors++; if (out_valid !== 1'b1 || out_data !== 4'd10) begin miscompares++; $display("FAIL arst_first_tick: valid=%b data=%0d want 1/10", out_valid, out_data); end
  endtask

  task automatic test_clear();
    mode = 2'b01;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = 4'(i + 1);
      cyc();
    end
    vectors++; if (overflow !== 1'b1 || count !== 3'd4) begin miscompares++; $display("FAIL clr_pre: ovf=%b count=%0d want 1/4", overflow, count); end
    clear = 1'b1;
    in_data = 4'd9;
    cyc();
    clear = 1'b0;
    in_valid = 1'b0;
    vectors++; if (count !== 3'd0 || overflow !== 1'b0 || empty !== 1'b1) begin miscompares++; $display("FAIL clr_state: count=%0d ovf=%b empty=%b want 0/0/1", count, overflow, empty); end
    vectors++; if (out_data !== 4'd0 || out_valid !== 1'b0) begin miscompares++; $display("FAIL clr_out: data=%0d valid=%b want 0/0", out_data, out_valid); end
    mode = 2'b10;
    for (int j = 0; j < 10; j++) begin
      cyc();
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL clr_play%0d: valid=%b want 0", j, out_valid); end
    end
  endtask

  task automatic test_onehot();
    mode = 2'b00;
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    mode = 2'b01;
    in_valid = 1'b1;
    in_data = 4'b0110;
    cyc();
    in_data = 4'b0000;
    cyc();
    in_valid = 1'b0;
`ifdef FIFO_SEQ_ONEHOT_EN
    vectors++; if (count !== 3'd1) begin miscompares++; $display("FAIL oh_count: got %0d want 1", count); end
`else
    vectors++; if (count !== 3'd2) begin miscompares++; $display("FAIL oh_count: got %0d want 2", count); end
`endif
    mode = 2'b10;
    cyc();
    for (int j = 0; j < 3; j++) cyc();
    cyc();
`ifdef FIFO_SEQ_ONEHOT_EN
    vectors++; if (out_valid !== 1'b1 || out_data !== 4'b0010) begin miscompares++; $display("FAIL oh_play: valid=%b data=%b want 1/0010", out_valid, out_data); end
`else
    vectors++; if (out_valid !== 1'b1 || out_data !== 4'b0110) begin miscompares++; $display("FAIL oh_play: valid=%b data=%b want 1/0110", out_valid, out_data); end
    for (int j = 0; j < 3; j++) cyc();
    cyc();
    vectors++; if (out_valid !== 1'b1 || out_data !== 4'b0000) begin miscompares++; $display("FAIL oh_zero: valid=%b data=%b want 1/0000", out_valid, out_data); end
`endif
    vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL oh_empty: got %b want 1", empty); end
  endtask

  initial begin
    test_reset();
    test_record_overflow();
    test_play();
    test_loop();
    test_async_reset();
    test_clear();
    test_onehot();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/fifo_seq_player.md
Name: fifo_seq_player

Overview:
- Parametrised record/playback sequencer that generalises the button-to-LED FIFO demo into a reusable block.
- Events of WIDTH bits are recorded into an internal 2^LOGDEPTH-entry ring buffer.
- Events are replayed one per PERIOD_CNT clocks in either one-shot (consuming) or loop (non-destructive) mode.
- Sits between the button_parser outputs and the LED/display registers in top-level designs.

Parameters:
- WIDTH, 4, event width in bits (one bit per input channel).
- LOGDEPTH, 3, log2 of buffer depth (8 entries).
- PERIOD_CNT, 125_000_000, clocks between playback ticks; must be >= 2.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- mode  input  2  00 HOLD, 01 RECORD, 10 PLAY, 11 LOOP.
- clear  input  1  synchronous flush of buffer and status.
- in_valid  input  1  event strobe, one cycle per event.
- in_data  input  WIDTH  event payload.
- out_data  output  WIDTH  last played event (registered).
- out_valid  output  1  one-cycle pulse when out_data is updated by a tick.
- count  output  LOGDEPTH+1  number of stored entries.
- full  output  1  count == 2^LOGDEPTH.
- empty  output  1  count == 0.
- overflow  output  1  sticky flag: an event was dropped while full.

Behaviour:
- Reset (async, rst=1): wr_ptr, rd_ptr, loop index, count, timer, mode_q, out_data, out_valid and overflow all go to 0 immediately. Therefore empty=1 and full=0. Memory contents are don't-care.
- Registered mode_q captures mode every cycle. A mode change is defined as mode != mode_q.
- Timer, PLAY/LOOP only:
  - On a mode change, or in HOLD/RECORD: timer <= 0.
  - Otherwise: timer wraps from PERIOD_CNT-1 to 0, else increments.
  - tick = (timer == PERIOD_CNT-1) && mode == mode_q && mode[1].
  - First tick is PERIOD_CNT edges after the edge that first samples the new mode, then every PERIOD_CNT edges.
- HOLD: no writes, no reads, and out_data holds its value.
- RECORD:
  - in_valid && !full: mem[wr_ptr] <= in_data, wr_ptr++ (wraps mod depth), count++.
  - in_valid && full: data dropped, overflow <= 1.
- PLAY (one-shot, consuming):
  - On tick with !empty: out_data <= mem[rd_ptr], rd_ptr++, count--, out_valid=1 for that cycle.
  - On tick with empty: nothing happens and out_valid stays 0.
  - out_data is retained after the buffer drains.
- LOOP (non-destructive):
  - Entering LOOP (mode change) sets loop index li <= 0.
  - On tick with !empty: out_data <= mem[rd_ptr+li] (address mod depth), out_valid=1. li <= (li == count-1) ? 0 : li+1.
  - count, rd_ptr and wr_ptr are unchanged.
  - With count == 1, the same entry repeats every tick.
- in_valid is ignored outside RECORD.
- clear (sync, highest non-reset priority):
  - pointers, li, count, timer, overflow and out_data go to 0; out_valid=0.
  - A concurrent in_valid or tick is discarded.
- out_valid is registered. It is high exactly the cycle after the tick edge, aligned with the new out_data.
- count width LOGDEPTH+1 distinguishes full from empty. Pointers are LOGDEPTH bits and wrap naturally.

Optional Feature:
- Macro: FIFO_SEQ_ONEHOT_EN.
- When defined: in RECORD, the stored value is the one-hot of the lowest set bit of in_data. For example, 4'b0110 stores 4'b0010.
- When defined: in_valid with in_data == 0 is ignored. It causes no write and no overflow.
- When undefined: in_data is stored verbatim, including all-zero values.

Test Plan (WIDTH=4, LOGDEPTH=2, PERIOD_CNT=4):
- Record 1,2,4,8, then a fifth event 3 -> count=4, full=1, overflow=1, and stored contents stay 1,2,4,8.
- Then switch to PLAY -> out_valid pulses with out_data 1,2,4,8 at edges 4,8,12,16 after the mode-sampling edge. empty=1 afterwards, with no further pulses, and out_data holds 8.
- Record 5,6,7, then LOOP -> out_data sequence 5,6,7,5,6 every 4 clocks, with count constant at 3.
- Assert rst asynchronously mid-PLAY, between clock edges -> out_data=0, count=0, empty=1 with no clock edge required. The first tick after release comes PERIOD_CNT edges after a mode change.
- In RECORD, clear together with in_valid=1, data=9 -> count=0 and overflow=0 next cycle. A following PLAY produces no out_valid.
- Macro defined: record 4'b0110 then PLAY -> out_data=4'b0010; record 0 -> count unchanged. Macro undefined: record 4'b0110 -> out_data=4'b0110.
